// File: rtl/kmeans_ctrl.sv
// kmeans_ctrl: sequencing controller for the K-means accelerator datapath.
// Steers the load stream into the centroid file and point SRAM, runs
// scan/accumulate iterations, schedules the shared divider per cluster,
// detects convergence and sequences the K-word result burst.
module kmeans_ctrl #(
   parameter int unsigned K        = 4,
   parameter int unsigned N        = 4096,
   parameter int unsigned MAX_ITER = 255,
   localparam int unsigned CW      = $clog2(K),
   localparam int unsigned AW      = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          cent_ld,
   output logic [CW-1:0] cent_idx,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          div_start,
   output logic [CW-1:0] div_idx,
   input  logic          div_done,
   input  logic          changed,
   output logic          out_valid,
   output logic [CW-1:0] out_sel,
   output logic [7:0]    iter_cnt,
   output logic          busy
);

   typedef enum logic [3:0] {
      IDLE,
      LOAD_C,
      LOAD_P,
      ITER_CLR,
      SCAN,
      DRAIN,
      DIV_GO,
      DIV_WAIT,
      CHECK,
      OUT
   } state_t;

   state_t     state;
   logic       any_chg;
   logic [7:0] iter_nxt;

   // Load strobes follow in_valid directly so the first word is taken in IDLE
   always_comb begin
      cent_ld  = in_valid && ((state == IDLE) || (state == LOAD_C));
      mem_we   = in_valid && (state == LOAD_P);
      iter_nxt = iter_cnt + 8'd1;
   end

   // Controller FSM; every other output is a register updated with the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cent_idx  <= '0;
         mem_addr  <= '0;
         acc_clr   <= 1'b0;
         acc_en    <= 1'b0;
         div_start <= 1'b0;
         div_idx   <= '0;
         out_valid <= 1'b0;
         out_sel   <= '0;
         iter_cnt  <= '0;
         busy      <= 1'b0;
         any_chg   <= 1'b0;
      end else begin
         acc_clr   <= 1'b0;
         div_start <= 1'b0;
         // SRAM read data arrives one cycle after the SCAN address
         acc_en    <= (state == SCAN);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= LOAD_C;
                  cent_idx <= CW'(1);
                  iter_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            LOAD_C: begin
               if (in_valid) begin
                  if (cent_idx == CW'(K - 1)) begin
                     state    <= LOAD_P;
                     cent_idx <= '0;
                     mem_addr <= '0;
                  end else begin
                     cent_idx <= cent_idx + CW'(1);
                  end
               end
            end
            LOAD_P: begin
               if (in_valid) begin
                  if (mem_addr == AW'(N - 1)) begin
                     state    <= ITER_CLR;
                     mem_addr <= '0;
                     acc_clr  <= 1'b1;
                  end else begin
                     mem_addr <= mem_addr + AW'(1);
                  end
               end
            end
            ITER_CLR: begin
               any_chg  <= 1'b0;
               mem_addr <= '0;
               state    <= SCAN;
            end
            SCAN: begin
               if (mem_addr == AW'(N - 1)) begin
                  state    <= DRAIN;
                  mem_addr <= '0;
               end else begin
                  mem_addr <= mem_addr + AW'(1);
               end
            end
            DRAIN: begin
               state     <= DIV_GO;
               div_idx   <= '0;
               div_start <= 1'b1;
            end
            DIV_GO: begin
               state <= DIV_WAIT;
            end
            DIV_WAIT: begin
               if (div_done) begin
                  any_chg <= any_chg | changed;
                  if (div_idx != CW'(K - 1)) begin
                     div_idx   <= div_idx + CW'(1);
                     div_start <= 1'b1;
                     state     <= DIV_GO;
                  end else begin
                     state <= CHECK;
                  end
               end
            end
            CHECK: begin
               iter_cnt <= iter_nxt;
               if (!any_chg || (iter_nxt == 8'(MAX_ITER))) begin
                  state     <= OUT;
                  out_valid <= 1'b1;
                  out_sel   <= '0;
               end else begin
                  state   <= ITER_CLR;
                  acc_clr <= 1'b1;
               end
            end
            OUT: begin
               if (out_sel == CW'(K - 1)) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_sel   <= '0;
                  busy      <= 1'b0;
               end else begin
                  out_sel <= out_sel + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kmeans_ctrl.sv
// tb_kmeans_ctrl: directed bench for kmeans_ctrl with a fixed-latency
// divider model (D=3) and a per-job event monitor.
module tb_kmeans_ctrl;

   localparam int K = 4;
   localparam int N = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance A: default MAX_ITER
   logic       iv_a = 1'b0, dd_a = 1'b0, chg_a = 1'b0, stray = 1'b0;
   logic       cent_ld_a, mem_we_a, acc_clr_a, acc_en_a, div_start_a, out_valid_a, busy_a;
   logic [1:0] cent_idx_a, div_idx_a, out_sel_a;
   logic [11:0] mem_addr_a;
   logic [7:0] iter_a;

   // instance B: MAX_ITER = 3
   logic       iv_b = 1'b0, dd_b = 1'b0, chg_b = 1'b0;
   logic       cent_ld_b, mem_we_b, acc_clr_b, acc_en_b, div_start_b, out_valid_b, busy_b;
   logic [1:0] cent_idx_b, div_idx_b, out_sel_b;
   logic [11:0] mem_addr_b;
   logic [7:0] iter_b;

   kmeans_ctrl #(.K(4), .N(4096), .MAX_ITER(255)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_a),
      .cent_ld(cent_ld_a), .cent_idx(cent_idx_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .acc_clr(acc_clr_a), .acc_en(acc_en_a), .div_start(div_start_a), .div_idx(div_idx_a),
      .div_done(dd_a | stray), .changed(chg_a), .out_valid(out_valid_a), .out_sel(out_sel_a),
      .iter_cnt(iter_a), .busy(busy_a));

   kmeans_ctrl #(.K(4), .N(4096), .MAX_ITER(3)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_b),
      .cent_ld(cent_ld_b), .cent_idx(cent_idx_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .acc_clr(acc_clr_b), .acc_en(acc_en_b), .div_start(div_start_b), .div_idx(div_idx_b),
      .div_done(dd_b), .changed(chg_b), .out_valid(out_valid_b), .out_sel(out_sel_b),
      .iter_cnt(iter_b), .busy(busy_b));

   int nchk = 0;
   int nfail = 0;
   int chg_mode = 0;   // 0: never changed, 1: cluster 2 in iteration 1 only, 2: always
   int job_id = 0;

   // divider model A: done pulse 3 cycles after the div_start cycle
   int dcnt_a = 0;
   int didx_a = 0;
   always @(negedge clk) begin
      dd_a = 1'b0;
      chg_a = 1'b0;
      if (dcnt_a != 0) begin
         dcnt_a = dcnt_a - 1;
         if (dcnt_a == 0) begin
            dd_a = 1'b1;
            chg_a = (chg_mode == 2) || (chg_mode == 1 && didx_a == 2 && iter_a == 8'd0);
         end
      end
      if (div_start_a) begin
         dcnt_a = 3;
         didx_a = int'(div_idx_a);
      end
   end

   // divider model B: same latency, centroid always reported as changed
   int dcnt_b = 0;
   always @(negedge clk) begin
      dd_b = 1'b0;
      chg_b = 1'b0;
      if (dcnt_b != 0) begin
         dcnt_b = dcnt_b - 1;
         if (dcnt_b == 0) begin
            dd_b = 1'b1;
            chg_b = 1'b1;
         end
      end
      if (div_start_b) dcnt_b = 3;
   end

   // per-job event monitor
   int seen_job = 0;
   int cyc = 0;
   int n_cent, cent_bad, n_we, we_bad, last_we, n_clr, clr1, n_accen, accen1;
   int n_divs, div_bad, n_out, out_bad, out1, out_iter;
   int n_clr_b, n_out_b, out_iter_b, out_bad_b;
   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (seen_job != job_id) begin
         seen_job = job_id;
         n_cent = 0; cent_bad = 0; n_we = 0; we_bad = 0; last_we = 0;
         n_clr = 0; clr1 = 0; n_accen = 0; accen1 = 0;
         n_divs = 0; div_bad = 0; n_out = 0; out_bad = 0; out1 = 0; out_iter = 0;
         n_clr_b = 0; n_out_b = 0; out_iter_b = 0; out_bad_b = 0;
      end
      if (cent_ld_a) begin
         if (int'(cent_idx_a) != n_cent % K) cent_bad++;
         n_cent++;
      end
      if (mem_we_a) begin
         if (int'(mem_addr_a) != n_we) we_bad++;
         n_we++;
         last_we = cyc;
      end
      if (acc_clr_a) begin
         if (n_clr == 0) clr1 = cyc;
         n_clr++;
      end
      if (acc_en_a) begin
         if (n_accen == 0) accen1 = cyc;
         n_accen++;
      end
      if (div_start_a) begin
         if (int'(div_idx_a) != n_divs % K) div_bad++;
         n_divs++;
      end
      if (out_valid_a) begin
         if (n_out == 0) out1 = cyc;
         if (int'(out_sel_a) != n_out % K) out_bad++;
         out_iter = int'(iter_a);
         n_out++;
      end
      if (acc_clr_b) n_clr_b++;
      if (out_valid_b) begin
         if (int'(out_sel_b) != n_out_b % K) out_bad_b++;
         out_iter_b = int'(iter_b);
         n_out_b++;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint pack_a();
      return longint'({cent_ld_a, cent_idx_a, mem_we_a, mem_addr_a, acc_clr_a, acc_en_a,
                       div_start_a, div_idx_a, out_valid_a, out_sel_a, iter_a, busy_a});
   endfunction

   task automatic feed(input int which, input int n);
      repeat (n) begin
         @(negedge clk);
         if (which == 0) iv_a = 1'b1; else iv_b = 1'b1;
      end
      @(negedge clk);
      iv_a = 1'b0;
      iv_b = 1'b0;
   endtask

   task automatic wait_idle(input int which, input int budget);
      logic b;
      b = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #3;
         b = (which == 0) ? busy_a : busy_b;
         if (!b) break;
      end
      chk("job_finished_busy", longint'(b), 0);
   endtask

   typedef struct {
      bit iv;
      bit cl;
      int ci;
      bit we;
      int addr;
      bit busy;
   } vec_t;

   vec_t tbl[10];

   initial begin
      bit found;
      // load start from IDLE with gaps: {in_valid, cent_ld, cent_idx, mem_we, mem_addr, busy}
      tbl[0] = '{0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 1, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 1, 0, 0, 1};
      tbl[3] = '{1, 1, 1, 0, 0, 1};
      tbl[4] = '{1, 1, 2, 0, 0, 1};
      tbl[5] = '{1, 1, 3, 0, 0, 1};
      tbl[6] = '{1, 0, 0, 1, 0, 1};
      tbl[7] = '{0, 0, 0, 0, 1, 1};
      tbl[8] = '{1, 0, 0, 1, 1, 1};
      tbl[9] = '{1, 0, 0, 1, 2, 1};

      #1;
      chk("reset_outputs", pack_a(), 0);
      chk("reset_busy_b", longint'(busy_b), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // job 1: gap-free load, converges after one iteration
      chg_mode = 0;
      job_id++;
      feed(0, K + N);
      wait_idle(0, 10000);
      chk("j1_cent_count", n_cent, 4);
      chk("j1_cent_order_errs", cent_bad, 0);
      chk("j1_we_count", n_we, 4096);
      chk("j1_we_addr_errs", we_bad, 0);
      chk("j1_clr_after_last_word", clr1, last_we + 1);
      chk("j1_clr_count", n_clr, 1);
      chk("j1_accen_count", n_accen, 4096);
      chk("j1_accen_first", accen1, clr1 + 2);
      chk("j1_div_count", n_divs, 4);
      chk("j1_div_idx_errs", div_bad, 0);
      chk("j1_out_count", n_out, 4);
      chk("j1_out_sel_errs", out_bad, 0);
      chk("j1_iter_cnt", out_iter, 1);
      chk("j1_iter_cycles", out1 - clr1, 4115);
      chk("j1_iter_hold_idle", longint'(iter_a), 1);

      // job 2: table-driven load start, stall after point 100, two iterations
      chg_mode = 1;
      job_id++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         iv_a = tbl[i].iv;
         #1;
         chk($sformatf("vec%0d_cent_ld", i), longint'(cent_ld_a), longint'(tbl[i].cl));
         chk($sformatf("vec%0d_cent_idx", i), longint'(cent_idx_a), longint'(tbl[i].ci));
         chk($sformatf("vec%0d_mem_we", i), longint'(mem_we_a), longint'(tbl[i].we));
         chk($sformatf("vec%0d_mem_addr", i), longint'(mem_addr_a), longint'(tbl[i].addr));
         chk($sformatf("vec%0d_busy", i), longint'(busy_a), longint'(tbl[i].busy));
      end
      repeat (98) begin
         @(negedge clk);
         iv_a = 1'b1;
      end
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         iv_a = 1'b0;
         #1;
         chk("stall_no_we", longint'(mem_we_a), 0);
         chk("stall_addr_held", longint'(mem_addr_a), 101);
      end
      @(negedge clk);
      iv_a = 1'b1;
      #1;
      chk("resume_we", longint'(mem_we_a), 1);
      chk("resume_addr", longint'(mem_addr_a), 101);
      feed(0, 3994);
      wait_idle(0, 20000);
      chk("j2_we_count", n_we, 4096);
      chk("j2_we_addr_errs", we_bad, 0);
      chk("j2_clr_count", n_clr, 2);
      chk("j2_accen_count", n_accen, 8192);
      chk("j2_div_count", n_divs, 8);
      chk("j2_out_count", n_out, 4);
      chk("j2_iter_cnt", out_iter, 2);

      // job 3: reset mid-SCAN, stray div_done, then a fresh job
      chg_mode = 0;
      job_id++;
      feed(0, K + N);
      found = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         #1;
         if (mem_addr_a == 12'd2000 && acc_en_a) begin
            found = 1'b1;
            break;
         end
      end
      chk("scan_addr_2000_seen", longint'(found), 1);
      chk("iter_cleared_new_job", longint'(iter_a), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", pack_a(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      #1;
      chk("stray_done_busy", longint'(busy_a), 0);
      chk("stray_done_outputs", pack_a(), 0);

      job_id++;
      feed(0, K + N);
      wait_idle(0, 10000);
      chk("j4_we_count", n_we, 4096);
      chk("j4_clr_count", n_clr, 1);
      chk("j4_out_count", n_out, 4);
      chk("j4_out_sel_errs", out_bad, 0);
      chk("j4_iter_cnt", out_iter, 1);

      // job 5: MAX_ITER=3 instance, never converges
      job_id++;
      feed(1, K + N);
      wait_idle(1, 20000);
      chk("cap_scan_count", n_clr_b, 3);
      chk("cap_out_count", n_out_b, 4);
      chk("cap_out_sel_errs", out_bad_b, 0);
      chk("cap_iter_cnt", out_iter_b, 3);
      chk("cap_busy_low", longint'(busy_b), 0);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
